// File: rtl/ram_arb_pkg.sv
// Shared types for the instruction/data RAM arbiter: requester ids, the
// response record and the address-legality check used by both ports.
package ram_arb_pkg;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  typedef struct packed {
    logic        valid;
    req_id_e     id;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  // Misaligned or beyond the end of the attached RAM.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= words);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the fetch port, bit 1 the data port.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   REQ_I | fetch was granted most recently, a conflict goes to data
//   REQ_D | data was granted most recently, a conflict goes to fetch
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last;
  req_id_e last_next;

  always_ff @(posedge clk) begin
    if (rst) last <= REQ_I;
    else     last <= last_next;
  end

  always_comb begin
    last_next = last;
    if (gnt[1])      last_next = REQ_D;
    else if (gnt[0]) last_next = REQ_I;
  end

  // No grants at all while reset is held, so nothing can start a RAM access.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) gnt = (last == REQ_I) ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-cycle RAM port between instruction fetch and load/store,
// answering every grant exactly one cycle later.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ram_r,
  output logic [3:0]  ram_w,
  output logic [31:0] ram_in,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_out
);

  logic [1:0]  gnt;
  logic        i_bad;
  logic        d_bad;
  logic        sel_valid;
  logic        sel_err;
  req_id_e     sel_id;
  logic [31:0] sel_data;
  rsp_t        rsp;
  logic        i_hit;
  logic        d_hit;
  logic [31:0] i_hold_data;
  logic [31:0] d_hold_data;
  logic        i_hold_err;
  logic        d_hold_err;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({d_req, i_req}),
    .gnt (gnt)
  );

  assign i_gnt = gnt[0];
  assign d_gnt = gnt[1];

  assign i_bad = addr_err(i_addr, WORDS);
  assign d_bad = addr_err(d_addr, WORDS) || (d_we && (d_be == 4'b0000));

  always_comb begin
    ram_r     = 1'b0;
    ram_w     = 4'b0000;
    ram_in    = 32'h0;
    ram_addr  = 32'h0;
    sel_valid = 1'b0;
    sel_err   = 1'b0;
    sel_id    = REQ_I;
    if (gnt[0]) begin
      sel_valid = 1'b1;
      sel_err   = i_bad;
      ram_addr  = i_addr;
      ram_r     = !i_bad;
    end else if (gnt[1]) begin
      sel_valid = 1'b1;
      sel_id    = REQ_D;
      sel_err   = d_bad;
      ram_addr  = d_addr;
      if (!d_bad) begin
        if (d_we) begin
          ram_w  = d_be;
          ram_in = d_wdata;
        end else begin
          ram_r = 1'b1;
        end
      end
    end
  end

  // Writes and rejected requests answer with zero data.
  assign sel_data = ram_r ? ram_out : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp <= '0;
    end else if (sel_valid) begin
      rsp.valid <= 1'b1;
      rsp.id    <= sel_id;
      rsp.err   <= sel_err;
      rsp.data  <= sel_data;
    end else begin
      rsp.valid <= 1'b0;
    end
  end

  // Per-port copies so each port keeps its own last answer while the other responds.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_hold_data <= 32'h0;
      i_hold_err  <= 1'b0;
      d_hold_data <= 32'h0;
      d_hold_err  <= 1'b0;
    end else if (rsp.valid) begin
      if (rsp.id == REQ_I) begin
        i_hold_data <= rsp.data;
        i_hold_err  <= rsp.err;
      end else begin
        d_hold_data <= rsp.data;
        d_hold_err  <= rsp.err;
      end
    end
  end

  assign i_hit = !rst && rsp.valid && (rsp.id == REQ_I);
  assign d_hit = !rst && rsp.valid && (rsp.id == REQ_D);

  assign i_rvalid = i_hit;
  assign d_rvalid = d_hit;
  assign i_rdata  = rst ? 32'h0 : (i_hit ? rsp.data : i_hold_data);
  assign d_rdata  = rst ? 32'h0 : (d_hit ? rsp.data : d_hold_data);
  assign i_err    = rst ? 1'b0  : (i_hit ? rsp.err  : i_hold_err);
  assign d_err    = rst ? 1'b0  : (d_hit ? rsp.err  : d_hold_err);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus a randomized
// run against a behavioural model of arbitration, errors and RAM contents.
module tb_ram_arbiter;

  localparam int WORDS = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        ram_r;
  logic [3:0]  ram_w;
  logic [31:0] ram_in, ram_addr, ram_out;

  int checks   = 0;
  int failures = 0;

  // Attached RAM (environment) and its backdoor load from the model image.
  logic [31:0] mem   [0:WORDS-1];
  logic [31:0] m_mem [0:WORDS-1];
  logic        bd_load = 1'b0;

  // Model state: pointer and expected per-port outputs.
  bit          m_last_d;
  bit          m_i_valid, m_d_valid, m_i_err, m_d_err;
  logic [31:0] m_i_data, m_d_data;

  always #5 clk = ~clk;

  ram_arbiter #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .ram_r(ram_r), .ram_w(ram_w), .ram_in(ram_in), .ram_addr(ram_addr),
    .ram_out(ram_out)
  );

  assign ram_out = ({2'b00, ram_addr[31:2]} < WORDS) ? mem[ram_addr[8:2]] : 32'h0;

  always @(posedge clk) begin
    if (bd_load) begin
      for (int k = 0; k < WORDS; k++) mem[k] <= m_mem[k];
    end else if ({2'b00, ram_addr[31:2]} < WORDS) begin
      for (int b = 0; b < 4; b++)
        if (ram_w[b]) mem[ram_addr[8:2]][8*b +: 8] <= ram_in[8*b +: 8];
    end
  end

  task automatic idle_inputs();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic model_reset();
    m_last_d = 0;
    m_i_valid = 0; m_d_valid = 0; m_i_err = 0; m_d_err = 0;
    m_i_data = 0; m_d_data = 0;
  endtask

  // Holds reset for n cycles, loading the RAM from the model image on the first.
  task automatic do_reset(input int n);
    rst = 1; idle_inputs(); bd_load = 1;
    @(posedge clk); #1; bd_load = 0;
    repeat (n - 1) @(posedge clk);
    #1; rst = 0;
    model_reset();
  endtask

  // win: 0 none, 1 fetch, 2 data.
  task automatic model_eval(output int win, output bit e, output logic [31:0] rd);
    bit ie, de;
    ie = (i_addr % 4 != 0) || (i_addr / 4 >= WORDS);
    de = (d_addr % 4 != 0) || (d_addr / 4 >= WORDS) || (d_we && d_be == 4'b0000);
    if (i_req && d_req) win = m_last_d ? 1 : 2;
    else if (i_req)     win = 1;
    else if (d_req)     win = 2;
    else                win = 0;
    e  = (win == 1) ? ie : (win == 2) ? de : 1'b0;
    rd = 32'h0;
    if (win == 1 && !ie)                 rd = m_mem[i_addr[8:2]];
    else if (win == 2 && !de && !d_we)   rd = m_mem[d_addr[8:2]];
  endtask

  task automatic model_edge(input int win, input bit e, input logic [31:0] rd);
    m_i_valid = (win == 1);
    m_d_valid = (win == 2);
    if (win == 1) begin m_i_err = e; m_i_data = rd; end
    if (win == 2) begin m_d_err = e; m_d_data = rd; end
    if (win != 0) m_last_d = (win == 2);
    if (win == 2 && !e && d_we)
      for (int b = 0; b < 4; b++)
        if (d_be[b]) m_mem[d_addr[8:2]][8*b +: 8] = d_wdata[8*b +: 8];
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 15);
    a = 32'($urandom_range(0, 15)) * 4;
    if (r == 0)      a = a + 32'($urandom_range(1, 3));
    else if (r == 1) a = 32'(WORDS + $urandom_range(0, 1000)) * 4;
    return a;
  endfunction

  task automatic test_reset();
    rst = 1; bd_load = 0;
    i_req = 1; i_addr = 0; d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 0; d_wdata = 32'hFFFF_FFFF;
    for (int ph = 0; ph < 2; ph++) begin
      #1;
      checks++; if ({i_gnt, d_gnt, ram_r, ram_w} !== 7'b0) begin failures++; $display("FAIL reset_strobes ph=%0d got=%b exp=0", ph, {i_gnt, d_gnt, ram_r, ram_w}); end
      checks++; if ({i_rvalid, d_rvalid, i_err, d_err} !== 4'b0) begin failures++; $display("FAIL reset_rsp ph=%0d got=%b exp=0000", ph, {i_rvalid, d_rvalid, i_err, d_err}); end
      checks++; if ({i_rdata, d_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata ph=%0d got=%h/%h exp=0", ph, i_rdata, d_rdata); end
      @(posedge clk);
    end
  endtask

  task automatic test_fetch_read();
    m_mem[3] = 32'hDEAD_BEEF;
    do_reset(2);
    i_req = 1; i_addr = 32'h0C; #1;
    checks++; if ({i_gnt, d_gnt} !== 2'b10) begin failures++; $display("FAIL fetch_gnt got=%b exp=10", {i_gnt, d_gnt}); end
    checks++; if ({ram_r, ram_w} !== 5'b10000) begin failures++; $display("FAIL fetch_strobe got=%b exp=10000", {ram_r, ram_w}); end
    checks++; if (ram_addr !== 32'h0C) begin failures++; $display("FAIL fetch_addr got=%h exp=0000000c", ram_addr); end
    @(posedge clk); #1; i_req = 0;
    checks++; if ({i_rvalid, d_rvalid, i_err} !== 3'b100) begin failures++; $display("FAIL fetch_rsp got=%b exp=100", {i_rvalid, d_rvalid, i_err}); end
    checks++; if (i_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", i_rdata); end
    @(posedge clk); #1;
    checks++; if (i_rvalid !== 1'b0) begin failures++; $display("FAIL fetch_single_pulse got=%b exp=0", i_rvalid); end
    checks++; if (i_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_hold got=%h exp=deadbeef", i_rdata); end
  endtask

  task automatic test_conflict();
    bit exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    m_mem[3] = 32'hDEAD_BEEF;
    m_mem[4] = 32'h4444_0004;
    do_reset(2);
    i_req = 1; i_addr = 32'h0C; d_req = 1; d_we = 0; d_addr = 32'h10;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({d_gnt, i_gnt} !== {exp_d[k], !exp_d[k]}) begin failures++; $display("FAIL conflict_gnt k=%0d got d/i=%b exp=%b", k, {d_gnt, i_gnt}, {exp_d[k], !exp_d[k]}); end
      if (k == 0) begin
        checks++; if ({d_rvalid, i_rvalid} !== 2'b00) begin failures++; $display("FAIL conflict_rv0 got=%b exp=00", {d_rvalid, i_rvalid}); end
      end else begin
        checks++; if ({d_rvalid, i_rvalid} !== {exp_d[k-1], !exp_d[k-1]}) begin failures++; $display("FAIL conflict_rv k=%0d got=%b exp=%b", k, {d_rvalid, i_rvalid}, {exp_d[k-1], !exp_d[k-1]}); end
        checks++; if ((exp_d[k-1] ? d_rdata : i_rdata) !== (exp_d[k-1] ? 32'h4444_0004 : 32'hDEAD_BEEF)) begin failures++; $display("FAIL conflict_data k=%0d got=%h/%h", k, d_rdata, i_rdata); end
      end
      @(posedge clk);
    end
    #1; idle_inputs();
    checks++; if ({d_rvalid, i_rvalid} !== 2'b01) begin failures++; $display("FAIL conflict_last_rv got=%b exp=01", {d_rvalid, i_rvalid}); end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    m_mem[4] = 32'h0;
    do_reset(1);
    d_req = 1; d_we = 1; d_be = 4'b0010; d_addr = 32'h10; d_wdata = 32'h0000_AB00; #1;
    checks++; if (d_gnt !== 1'b1) begin failures++; $display("FAIL wr_gnt got=%b exp=1", d_gnt); end
    checks++; if ({ram_r, ram_w} !== 5'b00010) begin failures++; $display("FAIL wr_strobe got=%b exp=00010", {ram_r, ram_w}); end
    checks++; if ({ram_addr, ram_in} !== {32'h10, 32'h0000_AB00}) begin failures++; $display("FAIL wr_bus got addr=%h in=%h", ram_addr, ram_in); end
    @(posedge clk); #1;
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h0}) begin failures++; $display("FAIL wr_ack got rv=%b err=%b data=%h exp 1/0/0", d_rvalid, d_err, d_rdata); end
    checks++; if (mem[4] !== 32'h0000_AB00) begin failures++; $display("FAIL wr_ram got=%h exp=0000ab00", mem[4]); end
    d_we = 0; #1;
    checks++; if ({d_gnt, ram_r, ram_w} !== 6'b110000) begin failures++; $display("FAIL rb_strobe got=%b exp=110000", {d_gnt, ram_r, ram_w}); end
    @(posedge clk); #1; d_req = 0;
    checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000_AB00}) begin failures++; $display("FAIL rb_data got rv=%b data=%h exp=1/0000ab00", d_rvalid, d_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    m_mem[2] = 32'h2222_0002;
    do_reset(1);
    d_req = 1; d_we = 0; d_addr = 32'h08;
    @(posedge clk); #1;
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b10, 32'h2222_0002}) begin failures++; $display("FAIL err_pre got rv=%b err=%b data=%h", d_rvalid, d_err, d_rdata); end
    d_addr = 32'h202; #1;
    checks++; if ({d_gnt, ram_r, ram_w} !== 6'b100000) begin failures++; $display("FAIL derr_strobe got=%b exp=100000", {d_gnt, ram_r, ram_w}); end
    @(posedge clk); #1;
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin failures++; $display("FAIL derr_rsp got rv=%b err=%b data=%h exp=1/1/0", d_rvalid, d_err, d_rdata); end
    d_req = 0; i_req = 1; i_addr = 32'h200; #1;
    checks++; if ({i_gnt, ram_r, ram_w} !== 6'b100000) begin failures++; $display("FAIL ierr_strobe got=%b exp=100000", {i_gnt, ram_r, ram_w}); end
    @(posedge clk); #1; i_req = 0;
    checks++; if ({i_rvalid, i_err, i_rdata} !== {2'b11, 32'h0}) begin failures++; $display("FAIL ierr_rsp got rv=%b err=%b data=%h exp=1/1/0", i_rvalid, i_err, i_rdata); end
    checks++; if ({d_rvalid, d_err} !== 2'b01) begin failures++; $display("FAIL derr_hold got=%b exp=01", {d_rvalid, d_err}); end
    d_req = 1; d_we = 1; d_be = 4'b0000; d_addr = 32'h08; d_wdata = 32'hFFFF_FFFF; #1;
    checks++; if ({d_gnt, ram_r, ram_w} !== 6'b100000) begin failures++; $display("FAIL be0_strobe got=%b exp=100000", {d_gnt, ram_r, ram_w}); end
    @(posedge clk); #1; idle_inputs();
    checks++; if ({d_rvalid, d_err, d_rdata} !== {2'b11, 32'h0}) begin failures++; $display("FAIL be0_rsp got rv=%b err=%b data=%h", d_rvalid, d_err, d_rdata); end
    checks++; if (mem[2] !== 32'h2222_0002) begin failures++; $display("FAIL be0_ram got=%h exp=22220002", mem[2]); end
  endtask

  task automatic test_reset_midstream();
    m_mem[3] = 32'h3333_0003;
    m_mem[5] = 32'h5A5A_5A5A;
    do_reset(1);
    d_req = 1; d_we = 0; d_addr = 32'h14;
    @(posedge clk); #1;
    d_we = 1; d_be = 4'hF; d_wdata = 32'hFFFF_0000; #1;
    checks++; if ({d_gnt, ram_w} !== 5'b11111) begin failures++; $display("FAIL mid_granted got=%b exp=11111", {d_gnt, ram_w}); end
    rst = 1; #1;
    checks++; if ({d_gnt, ram_r, ram_w} !== 6'b0) begin failures++; $display("FAIL mid_blocked got=%b exp=0", {d_gnt, ram_r, ram_w}); end
    @(posedge clk); #1;
    checks++; if ({d_rvalid, i_rvalid} !== 2'b00) begin failures++; $display("FAIL mid_no_rvalid got=%b exp=00", {d_rvalid, i_rvalid}); end
    checks++; if (mem[5] !== 32'h5A5A_5A5A) begin failures++; $display("FAIL mid_ram got=%h exp=5a5a5a5a", mem[5]); end
    rst = 0; d_we = 0; i_req = 1; i_addr = 32'h0C; #1;
    checks++; if ({d_gnt, i_gnt} !== 2'b10) begin failures++; $display("FAIL mid_first_conflict got d/i=%b exp=10", {d_gnt, i_gnt}); end
    @(posedge clk); #1; idle_inputs();
    checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h5A5A_5A5A}) begin failures++; $display("FAIL mid_after got rv=%b data=%h", d_rvalid, d_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int win;
    bit e;
    logic [31:0] rd;
    bit exp_r;
    logic [3:0] exp_w;
    for (int k = 0; k < WORDS; k++) m_mem[k] = $urandom;
    do_reset(2);
    for (int n = 0; n < 400; n++) begin
      i_req = ($urandom_range(0, 9) < 7);
      d_req = ($urandom_range(0, 9) < 7);
      d_we = 1'($urandom_range(0, 1));
      d_be = 4'($urandom_range(0, 15));
      i_addr = rnd_addr();
      d_addr = rnd_addr();
      d_wdata = $urandom;
      #1;
      model_eval(win, e, rd);
      exp_r = (win == 1 && !e) || (win == 2 && !e && !d_we);
      exp_w = (win == 2 && !e && d_we) ? d_be : 4'b0000;
      checks++; if ({i_gnt, d_gnt} !== {win == 1, win == 2}) begin failures++; $display("FAIL rnd_gnt n=%0d got i/d=%b exp win=%0d", n, {i_gnt, d_gnt}, win); end
      checks++; if ({ram_r, ram_w} !== {exp_r, exp_w}) begin failures++; $display("FAIL rnd_strobe n=%0d got=%b exp=%b", n, {ram_r, ram_w}, {exp_r, exp_w}); end
      if (exp_r || exp_w != 0) begin
        checks++; if (ram_addr !== ((win == 1) ? i_addr : d_addr)) begin failures++; $display("FAIL rnd_addr n=%0d got=%h", n, ram_addr); end
      end
      if (exp_w != 0) begin
        checks++; if (ram_in !== d_wdata) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, ram_in, d_wdata); end
      end
      @(posedge clk);
      model_edge(win, e, rd);
      #1;
      checks++; if ({i_rvalid, i_err, i_rdata} !== {m_i_valid, m_i_err, m_i_data}) begin failures++; $display("FAIL rnd_i_rsp n=%0d got rv=%b err=%b data=%h exp %b/%b/%h", n, i_rvalid, i_err, i_rdata, m_i_valid, m_i_err, m_i_data); end
      checks++; if ({d_rvalid, d_err, d_rdata} !== {m_d_valid, m_d_err, m_d_data}) begin failures++; $display("FAIL rnd_d_rsp n=%0d got rv=%b err=%b data=%h exp %b/%b/%h", n, d_rvalid, d_err, d_rdata, m_d_valid, m_d_err, m_d_data); end
    end
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) m_mem[k] = 32'h0;
    test_reset();
    test_fetch_read();
    test_conflict();
    test_byte_write();
    test_errors();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WORDS, default 128, number of 32-bit words in the attached RAM.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports i_req input 1, i_addr input 32: instruction-fetch read request and byte address.
REQ-005 SHALL have ports i_gnt output 1, i_rvalid output 1, i_rdata output 32, i_err output 1: fetch grant, response strobe, data and error.
REQ-006 SHALL have ports d_req input 1, d_we input 1, d_be input 4, d_addr input 32, d_wdata input 32: load/store request, write flag, byte enables, byte address and write data.
REQ-007 SHALL have ports d_gnt output 1, d_rvalid output 1, d_rdata output 32, d_err output 1: load/store grant, response strobe, data and error.
REQ-008 SHALL have ports ram_r output 1, ram_w output 4, ram_in output 32, ram_addr output 32, ram_out input 32: the single RAM port (combinational read, byte-lane write).

Function
REQ-009 SHALL grant at most one requester per cycle; gnt is combinational from req and the arbitration pointer.
REQ-010 With only one requester active, that requester SHALL be granted in the same cycle.
REQ-011 On conflict, the requester not granted most recently SHALL win (2-way round robin); the pointer SHALL update only on a cycle with a grant.
REQ-012 In the grant cycle, the granted request SHALL drive ram_addr; reads drive ram_r=1 and ram_w=0; data writes drive ram_w=d_be, ram_in=d_wdata and ram_r=0.
REQ-013 With no grant, or on an error grant, ram_r SHALL be 0 and ram_w SHALL be 4'b0000.
REQ-014 A granted request SHALL be completed exactly one cycle later: the matching rvalid high for one cycle.
REQ-015 For a read, rdata SHALL be ram_out registered at the grant-cycle posedge.
REQ-016 For a write, d_rvalid SHALL still pulse as an acknowledge, and d_rdata SHALL be 0.
REQ-017 A request SHALL be an error when addr[1:0]!=0 or addr[31:2]>=WORDS, or, for a data write only, when d_be==0.
REQ-018 An error request SHALL be granted without any RAM access; its response SHALL give err=1 and rdata=0.
REQ-019 The arbiter SHALL sustain back-to-back grants each cycle, with no bubble between consecutive accesses.
REQ-020 The losing requester SHALL see gnt=0 and hold its request; the arbiter SHALL NOT buffer it.
REQ-021 rdata/err SHALL hold their last values while rvalid=0.

Reset
REQ-022 While rst=1: i_rvalid, d_rvalid, i_err and d_err SHALL be 0, and i_rdata and d_rdata SHALL be 0.
REQ-023 While rst=1: the pointer SHALL be "fetch last", so the first conflict goes to data; gnt outputs and RAM strobes SHALL be 0.
REQ-024 A grant in the cycle where rst rises SHALL produce no response, and no RAM write SHALL occur during reset.

Structure
REQ-025 Package ram_arb_pkg SHALL hold the requester-id enum (REQ_I, REQ_D) and the response-record typedef {valid, id, err, data}.
REQ-026 The two-way round-robin SHALL be the sub-module rr_arb2 (req[1:0], gnt[1:0], last-pointer register).
REQ-027 The response stage SHALL be a single register of the package record type.

Verification
REQ-028 The bench SHALL cover fetch-only reads: rst released, RAM word 3=32'hDEADBEEF, i_req with i_addr=0x0C -> i_gnt same cycle, i_rvalid next cycle, i_rdata=32'hDEADBEEF, i_err=0.
REQ-029 The bench SHALL cover a conflict sequence: both req held 4 cycles after reset -> grants D,I,D,I, and rvalid pulses follow each grant by one cycle.
REQ-030 The bench SHALL cover a byte write: d_we=1, d_be=4'b0010, d_addr=0x10, d_wdata=32'h0000AB00 over a word of 0 -> ram_w=4'b0010 in the grant cycle, then d_rvalid with d_rdata=0; a readback gives 32'h0000AB00.
REQ-031 The bench SHALL cover errors: d_addr=0x202 with WORDS=128, and separately i_addr=0x200 -> ram_r=0 and ram_w=0, with err=1 and rdata=0 on the next-cycle response.
REQ-032 The bench SHALL cover reset mid-stream: rst asserted during a granted write -> no rvalid afterwards, and the RAM word is unchanged; after release, the first conflict goes to D.
